// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined signed ALU.
package alu_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf;
        logic carry;
    } alu_flags_t;

    // Largest positive signed value of width w (caller truncates to w bits).
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative signed value of width w (caller truncates to w bits).
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative signed shift-add multiplier: one partial product per cycle on
// operand magnitudes, sign applied to the full 2*WIDTH product at the end.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH);

    // |-2^(WIDTH-1)| needs one extra bit, hence WIDTH+1-bit magnitudes.
    function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] ext;
        ext = {x[WIDTH-1], x};
        return x[WIDTH-1] ? (~ext + 1'b1) : ext;
    endfunction

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH:0]     mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [CNT_W-1:0]   cnt;
    logic               run;
    logic               neg;

    // Accumulator value after the current step; on the last step this is the
    // final magnitude, so the product is available combinationally with done.
    always_comb begin
        acc_nx  = acc + (mplier[0] ? mcand : '0);
        done    = run && (cnt == CNT_W'(WIDTH - 1));
        product = neg ? -acc_nx : acc_nx;
    end

    // Step sequencer; holds on the final step while the consumer is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            neg    <= 1'b0;
        end else if (start) begin
            mcand  <= {{(WIDTH-1){1'b0}}, mag(a)};
            mplier <= mag(b);
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
            neg    <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (run && !stall) begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
                run <= 1'b0;
            end else begin
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Signed ALU with valid/ready on both sides and a registered result.
// Single-cycle ops complete in one cycle; MUL runs the iterative multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int OPCODE_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                sat_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                flag_zero,
    output logic                flag_neg,
    output logic                flag_ovf,
    output logic                flag_carry,
    output logic                busy
);
    localparam logic [WIDTH-1:0] S_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] S_MIN = WIDTH'(sat_min(WIDTH));

    alu_op_e            op;
    alu_state_e         state_q, state_d;
    alu_flags_t         flags_q;
    logic [WIDTH-1:0]   res_q;
    logic               mul_sat_q;

    logic               accept, is_mul, can_load, mul_fin;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     sum_x, dif_x, prod_hi;
    logic [WIDTH-1:0]   alu_res, mul_res;
    logic               alu_ovf, alu_carry, mul_ovf, shift_big;

    assign op       = alu_op_e'(opcode);
    assign is_mul   = (op == OP_MUL);
    assign can_load = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign mul_fin  = (state_q == MUL_RUN) && mul_done && can_load;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .stall   (mul_done && !can_load),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle datapath; overflow is judged on the raw result before saturation.
    always_comb begin
        sum_x     = {1'b0, a} + {1'b0, b};
        dif_x     = {1'b0, a} - {1'b0, b};
        shift_big = {1'b0, b} >= (WIDTH+1)'(WIDTH);
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum_x[WIDTH-1:0];
                alu_carry = sum_x[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_x[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = dif_x[WIDTH-1:0];
                alu_carry = dif_x[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_x[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = shift_big ? '0 : (a << b);
            OP_SHR:  alu_res = shift_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
            default: alu_res = '0;
        endcase
        // On ADD/SUB overflow the true result carries a's sign.
        if (sat_en && alu_ovf)
            alu_res = a[WIDTH-1] ? S_MIN : S_MAX;
    end

    // Product fits WIDTH signed bits only if its top WIDTH+1 bits are all equal.
    always_comb begin
        prod_hi = mul_prod[2*WIDTH-1:WIDTH-1];
        mul_ovf = !((&prod_hi) || !(|prod_hi));
        mul_res = mul_prod[WIDTH-1:0];
        if (mul_sat_q && mul_ovf)
            mul_res = mul_prod[2*WIDTH-1] ? S_MIN : S_MAX;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_mul) state_d = MUL_RUN;
            MUL_RUN: if (mul_fin)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = (state_q == IDLE) && can_load;
        busy     = (state_q == MUL_RUN);
    end

    // Output register: loads on completion, holds while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            res_q     <= '0;
            flags_q   <= '0;
            mul_sat_q <= 1'b0;
        end else begin
            if (accept && is_mul)
                mul_sat_q <= sat_en;
            if (accept && !is_mul) begin
                out_valid <= 1'b1;
                res_q     <= alu_res;
                flags_q   <= '{zero: (alu_res == '0), neg: alu_res[WIDTH-1],
                               ovf: alu_ovf, carry: alu_carry};
            end else if (mul_fin) begin
                out_valid <= 1'b1;
                res_q     <= mul_res;
                flags_q   <= '{zero: (mul_res == '0), neg: mul_res[WIDTH-1],
                               ovf: mul_ovf, carry: 1'b0};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign result     = res_q;
    assign flag_zero  = flags_q.zero;
    assign flag_neg   = flags_q.neg;
    assign flag_ovf   = flags_q.ovf;
    assign flag_carry = flags_q.carry;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Second-generation, parametrised signed ALU with valid/ready handshakes on input and output, and a registered result.
- Adds XOR, shift and iterative multiply ops, optional saturation, and status flags.
- Sits between an operand source and a result consumer; either side may stall.
- Single-cycle ops have 1-cycle latency. MUL runs as a multi-cycle FSM.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4); all arithmetic is signed two's complement.
- OPCODE_W, 3, opcode width; fixed at 3 for this generation.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A, signed.
- b  input  WIDTH  operand B, signed; the shift amount for SHL/SHR.
- opcode  input  OPCODE_W  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (arithmetic), 111 MUL.
- sat_en  input  1  saturate ADD/SUB/MUL on signed overflow; sampled with the operands.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  signed result.
- flag_zero  output  1  result == 0.
- flag_neg  output  1  result MSB.
- flag_ovf  output  1  signed overflow, computed before saturation.
- flag_carry  output  1  ADD: unsigned carry-out; SUB: unsigned borrow (a<b unsigned); all other ops 0.
- busy  output  1  MUL in progress.

Behaviour:
- Reset: out_valid=0, result=0, all flags=0, busy=0, FSM=IDLE, in_ready=1 on the cycle after release.
- Accept occurs on a cycle with in_valid && in_ready. a, b, opcode and sat_en are captured in that cycle only.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back throughput of 1 op/cycle for non-MUL ops.
- Output register: loads on completion. While out_valid && !out_ready, result and flags hold stable. out_valid drops after the handshake unless a new result loads in the same cycle.
- Non-MUL op accepted in cycle N: out_valid=1 in cycle N+1.
- ADD/SUB:
  - Compute at WIDTH+1 bits.
  - ovf = sign mismatch of operands/result per the standard rule.
  - With sat_en=1 and ovf=1, result = +2^(WIDTH-1)-1 or -2^(WIDTH-1) by the sign of the true result. ovf stays 1.
- AND/OR/XOR: bitwise; ovf=0, carry=0.
- SHL/SHR:
  - The shift amount is b taken as unsigned.
  - If amount >= WIDTH, SHL gives 0 and SHR gives all copies of a's sign bit.
  - ovf=0.
- MUL (FSM IDLE -> MUL_RUN -> IDLE):
  - On accept, latch |a| and |b| and the sign product; busy=1.
  - MUL_RUN performs one shift-add step per cycle for WIDTH cycles, counter 0..WIDTH-1.
  - On the last step, apply sign to the 2*WIDTH product and load the low WIDTH bits. ovf=1 if the true product is not representable in WIDTH signed bits; saturate if sat_en.
  - Accepted in cycle N -> out_valid in cycle N+WIDTH+1. in_ready=0 and busy=1 throughout.
  - MUL_RUN completion waits (holding state) if the output register is still occupied and out_ready=0.
- Boundaries:
  - -2^(WIDTH-1) * -1 overflows: ovf=1; with sat_en it saturates to max positive.
  - Magnitude of -2^(WIDTH-1) requires a WIDTH+1-bit internal magnitude.
  - Reset mid-MUL aborts the operation. No result is emitted; the FSM returns to IDLE.
- No X propagation: when out_valid=0, result holds its last value.

Decomposition:
- alu_pkg:
  - alu_op_e opcode enum.
  - alu_state_e {IDLE, MUL_RUN}.
  - alu_flags_t struct {zero, neg, ovf, carry}.
  - Saturation min/max helper functions parametrised by width.
- Sub-module alu_mul_seq: iterative signed shift-add multiplier.
  - Ports: start, a, b, done, product[2*WIDTH-1:0].
  - The top level owns the handshake, saturation and output register.

Test Plan:
- WIDTH=8, ADD 10+20, out_ready=1 -> result 30 at N+1, all flags 0. Back-to-back SUB 10-20 at N+1 -> result -10, neg=1, carry=1 at N+2.
- ADD 100+100, sat_en=0 -> result -56, ovf=1, neg=1. Same with sat_en=1 -> result 127, ovf=1. SUB -128-1, sat_en=1 -> -128, ovf=1.
- MUL -7*9 -> -63 exactly at N+9, in_ready=0 and busy=1 for cycles N+1..N+8. MUL 16*16, sat_en=1 -> 127, ovf=1. MUL -128*-1, sat_en=0 -> -128, ovf=1.
- out_ready=0, AND 0x0F&0x3C -> 0x0C with out_valid held and in_ready=0. Raise out_ready -> handshake, and OR 0x0F|0x30 = 0x3F accepted the same cycle.
- SHL 1 by b=9 -> 0, zero=1. SHR -128 by 3 -> -16. SHR -128 by 200 -> -1. XOR 0x55^0x55 -> 0, zero=1.
- Drive reset low at cycle N+4 of a MUL -> out_valid=0, busy=0. After release, ADD 1+1 -> 2 at N+1. Repeat the ADD/MUL cases with WIDTH=16: 230+300=530, 230*-3=-690.
